// File: rtl/vec_alu_if.sv
// Host access and run-control bundle for vec_alu_engine.
// The sat_o status line exists only when VEC_ALU_SAT_EN is defined.
interface vec_alu_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
);
    logic [1:0]            host_sel_i;
    logic                  host_en_i;
    logic                  host_we_i;
    logic [ADDR_WIDTH-1:0] host_addr_i;
    logic [DATA_WIDTH-1:0] host_wdata_i;
    logic [DATA_WIDTH-1:0] host_rdata_o;
    logic                  start_i;
    logic [ADDR_WIDTH-1:0] base_i;
    logic [ADDR_WIDTH:0]   len_i;
    logic                  busy_o;
    logic                  done_o;
    logic [ADDR_WIDTH:0]   count_o;
`ifdef VEC_ALU_SAT_EN
    logic                  sat_o;
`endif

    modport slave (
        input  host_sel_i, host_en_i, host_we_i, host_addr_i, host_wdata_i,
        input  start_i, base_i, len_i,
        output host_rdata_o, busy_o, done_o, count_o
`ifdef VEC_ALU_SAT_EN
        , output sat_o
`endif
    );

    modport master (
        output host_sel_i, host_en_i, host_we_i, host_addr_i, host_wdata_i,
        output start_i, base_i, len_i,
        input  host_rdata_o, busy_o, done_o, count_o
`ifdef VEC_ALU_SAT_EN
        , input sat_o
`endif
    );
endinterface

// File: rtl/vec_alu_engine.sv
// Vector ALU engine: A/B/OP/RESULT memories, host port and a run controller
// streaming base..base+len-1 through a one-stage read pipeline. Optional macro: VEC_ALU_SAT_EN.
module vec_alu_engine #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int OP_WIDTH   = 3
) (
    input  logic     CLK,
    input  logic     RST,
    vec_alu_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int SHW   = $clog2(DATA_WIDTH);
    localparam int LW    = ADDR_WIDTH + 1;
    localparam int MSB   = DATA_WIDTH - 1;
    localparam logic [DATA_WIDTH-1:0] ZERO_W = {DATA_WIDTH{1'b0}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_EXEC  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Opcodes above 7 (only possible with wider OP fields) yield zero.
    function automatic logic [DATA_WIDTH-1:0] alu_f(
        input logic [DATA_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] b,
        input logic [OP_WIDTH-1:0]   op
    );
        logic [31:0]           opx;
        logic [DATA_WIDTH-1:0] r;
        opx = 32'(op);
        r   = ZERO_W;
        if (opx > 32'd7) begin
            r = ZERO_W;
        end else begin
            case (opx[2:0])
                3'd0:    r = a + b;
                3'd1:    r = a - b;
                3'd2:    r = a & b;
                3'd3:    r = a | b;
                3'd4:    r = a ^ b;
                3'd5:    r = a << b[SHW-1:0];
                3'd6:    r = a >> b[SHW-1:0];
                3'd7:    r = a;
                default: r = ZERO_W;
            endcase
        end
        return r;
    endfunction

`ifdef VEC_ALU_SAT_EN
    localparam logic [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    // Signed overflow of ADD/SUB: result sign disagrees with what the operand signs allow.
    function automatic logic ovf_f(
        input logic [DATA_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] b,
        input logic [OP_WIDTH-1:0]   op
    );
        logic [31:0]           opx;
        logic [DATA_WIDTH-1:0] s;
        logic [DATA_WIDTH-1:0] d;
        logic                  o;
        opx = 32'(op);
        s   = a + b;
        d   = a - b;
        if (opx == 32'd0) begin
            o = (a[MSB] == b[MSB]) && (s[MSB] != a[MSB]);
        end else if (opx == 32'd1) begin
            o = (a[MSB] != b[MSB]) && (d[MSB] != a[MSB]);
        end else begin
            o = 1'b0;
        end
        return o;
    endfunction
`endif

    logic [DATA_WIDTH-1:0] mem_a_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_b_q [DEPTH];
    logic [OP_WIDTH-1:0]   mem_op_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_r_q [DEPTH];

    state_t                state_q, state_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [ADDR_WIDTH-1:0] rd_idx_q;
    logic [ADDR_WIDTH-1:0] wr_idx_q;
    logic [LW-1:0]         rem_q;
    logic [LW-1:0]         count_q;
    logic                  valid_q;
    logic [DATA_WIDTH-1:0] a_q, b_q;
    logic [OP_WIDTH-1:0]   op_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [DATA_WIDTH-1:0] alu_res_s;
    logic                  host_idle_s;
    logic                  host_wr_s;
    logic                  host_rd_s;
    logic                  start_take_s;

    assign host_idle_s  = (state_q == S_IDLE) || (state_q == S_DONE);
    assign host_wr_s    = bus.host_en_i && bus.host_we_i && host_idle_s;
    assign host_rd_s    = bus.host_en_i && !bus.host_we_i && host_idle_s;
    assign start_take_s = (state_q == S_IDLE) && bus.start_i;

`ifdef VEC_ALU_SAT_EN
    logic alu_ovf_s;
    logic sat_q;
    assign alu_ovf_s = ovf_f(a_q, b_q, op_q);
    assign alu_res_s = alu_ovf_s ? (a_q[MSB] ? SAT_MIN : SAT_MAX) : alu_f(a_q, b_q, op_q);
    assign bus.sat_o = sat_q;

    // Sticky saturation flag, cleared when a run is accepted
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sat_q <= 1'b0;
        end else if (start_take_s) begin
            sat_q <= 1'b0;
        end else if (valid_q && alu_ovf_s) begin
            sat_q <= 1'b1;
        end else begin
            sat_q <= sat_q;
        end
    end
`else
    assign alu_res_s = alu_f(a_q, b_q, op_q);
`endif

    // Run controller state register
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; DONE waits for start_i to drop before re-arming
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start_i) begin
                    state_d = (bus.len_i == LW'(0)) ? S_DONE : S_EXEC;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_EXEC: begin
                if (rem_q == LW'(1)) begin
                    state_d = S_DRAIN;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_DRAIN: state_d = S_DONE;
            S_DONE: begin
                if (!bus.start_i) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Status decode from the upcoming state so the registered flags track the state register
    always_comb begin
        busy_d = (state_d == S_EXEC) || (state_d == S_DRAIN);
        done_d = (state_d == S_DONE);
    end

    // Pipeline, counters, status flags and host read data
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            rd_idx_q <= {ADDR_WIDTH{1'b0}};
            wr_idx_q <= {ADDR_WIDTH{1'b0}};
            rem_q    <= {LW{1'b0}};
            count_q  <= {LW{1'b0}};
            valid_q  <= 1'b0;
            a_q      <= ZERO_W;
            b_q      <= ZERO_W;
            op_q     <= {OP_WIDTH{1'b0}};
            rdata_q  <= ZERO_W;
        end else begin
            busy_q  <= busy_d;
            done_q  <= done_d;
            valid_q <= (state_q == S_EXEC);

            if (start_take_s) begin
                rd_idx_q <= bus.base_i;
                rem_q    <= bus.len_i;
            end else if (state_q == S_EXEC) begin
                rd_idx_q <= rd_idx_q + ADDR_WIDTH'(1);
                rem_q    <= rem_q - LW'(1);
                wr_idx_q <= rd_idx_q;
                a_q      <= mem_a_q[rd_idx_q];
                b_q      <= mem_b_q[rd_idx_q];
                op_q     <= mem_op_q[rd_idx_q];
            end else begin
                rd_idx_q <= rd_idx_q;
                rem_q    <= rem_q;
            end

            if (start_take_s) begin
                count_q <= {LW{1'b0}};
            end else if (valid_q) begin
                count_q <= count_q + LW'(1);
            end else begin
                count_q <= count_q;
            end

            // Read data holds whenever no read is accepted, including the whole run
            if (host_rd_s) begin
                case (bus.host_sel_i)
                    2'd0:    rdata_q <= mem_a_q[bus.host_addr_i];
                    2'd1:    rdata_q <= mem_b_q[bus.host_addr_i];
                    2'd2:    rdata_q <= DATA_WIDTH'(mem_op_q[bus.host_addr_i]);
                    2'd3:    rdata_q <= mem_r_q[bus.host_addr_i];
                    default: rdata_q <= rdata_q;
                endcase
            end else begin
                rdata_q <= rdata_q;
            end
        end
    end

    // Memory writes: host only while idle/done, results only while the pipeline is valid
    always_ff @(posedge CLK) begin
        if (host_wr_s) begin
            case (bus.host_sel_i)
                2'd0:    mem_a_q[bus.host_addr_i]  <= bus.host_wdata_i;
                2'd1:    mem_b_q[bus.host_addr_i]  <= bus.host_wdata_i;
                2'd2:    mem_op_q[bus.host_addr_i] <= bus.host_wdata_i[OP_WIDTH-1:0];
                2'd3:    mem_r_q[bus.host_addr_i]  <= bus.host_wdata_i;
                default: ;
            endcase
        end
        if (valid_q) begin
            mem_r_q[wr_idx_q] <= alu_res_s;
        end
    end

    assign bus.host_rdata_o = rdata_q;
    assign bus.busy_o       = busy_q;
    assign bus.done_o       = done_q;
    assign bus.count_o      = count_q;

endmodule
